hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS-style core.
- Produces the select lines that drive the EX-stage operand forwarding muxes, plus the stall, bubble and flush controls for the pipeline registers.
- The forwarding selects are decided in ID and registered into the ID/EX boundary, so they are valid at the EX muxes with no combinational path from the EX/MEM compare.
- Contains a small state machine for load-use stalls and multicycle data-memory waits, and a saturating stall counter.

Parameters:
- CNT_W, 16, width of stall_cnt (saturating performance counter).
- REG_W, 5, register-index width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous reset, active low
- id_rs, id_rt  in  REG_W  source register indices of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- ex_rd  in  REG_W  destination index of the instruction in EX
- ex_reg_write, ex_mem_read  in  1  EX instruction writes a register / is a load
- mem_rd  in  REG_W  destination index of the instruction in MEM
- mem_reg_write  in  1  MEM instruction writes a register
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- mem_busy  in  1  data memory not ready; MEM stage must hold
- fwd_a_sel, fwd_b_sel  out  2  EX operand A / B source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- pc_write, ifid_write  out  1  enable PC / IF-ID register update
- ifid_flush, idex_bubble  out  1  zero the IF/ID instruction / insert NOP into ID/EX
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB (memory wait)
- stall_cnt  out  CNT_W  count of non-advancing cycles, saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN; fwd_a_sel=fwd_b_sel=00; stall_cnt=0.
  - Combinational outputs evaluate with state=RUN.
- States: RUN, LOAD_STALL, MEM_WAIT.
- Hazard terms:
  - load_hz = ex_mem_read & ex_rd!=0 & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
  - Register 0 never matches.
- Control priority each cycle, highest first: mem_busy > ex_branch_taken > load_hz.
  1. mem_busy=1:
     - pc_write=0, ifid_write=0, pipe_freeze=1, ifid_flush=0, idex_bubble=0.
     - fwd selects hold.
     - next state MEM_WAIT; stays there while mem_busy=1, returns to RUN the first cycle mem_busy=0.
     - A branch or load hazard present during the wait is evaluated in that release cycle.
  2. ex_branch_taken=1 (mem_busy=0):
     - pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
     - fwd selects <= 00.
     - load_hz ignored (the ID instruction is being killed).
     - state=RUN.
  3. load_hz=1 in RUN:
     - pc_write=0, ifid_write=0, idex_bubble=1.
     - fwd selects <= 00.
     - state -> LOAD_STALL.
     - In LOAD_STALL the load is now in MEM, so load_hz is false by construction. The state returns to RUN next cycle and advances normally.
     - LOAD_STALL never lasts more than 1 cycle unless mem_busy intervenes.
  4. Otherwise (advance):
     - pc_write=1, ifid_write=1, all flush/bubble/freeze=0.
     - fwd_a_sel <= 01 if id_uses_rs & ex_reg_write & ex_rd!=0 & ex_rd==id_rs;
       else 10 if id_uses_rs & mem_reg_write & mem_rd!=0 & mem_rd==id_rs;
       else 00.
     - The EX match has priority, since it is the newer value.
     - fwd_b_sel uses the same rule with id_rt/id_uses_rt.
- Latency:
  - fwd selects are registered, valid the cycle the instruction occupies EX.
  - Stall/flush controls are combinational, same cycle.
- stall_cnt:
  - Increments by 1 on every cycle with pc_write=0.
  - Saturates at all-ones (no wrap).
  - Cleared only by reset.
- Reset asserted mid-stall or mid-wait: immediate return to RUN with all registers cleared; no pending stall is remembered.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle in MEM_WAIT -> state RUN, fwd_a_sel=fwd_b_sel=00, stall_cnt=0, pc_write=1 with all inputs 0.
- EX forward: ex_rd=5, ex_reg_write=1, id_rs=5, id_uses_rs=1, mem_rd=5, mem_reg_write=1 -> next cycle fwd_a_sel=01 (EX wins). With ex_rd=0 and id_rs=0 instead -> fwd_a_sel=00.
- Load-use: ex_mem_read=1, ex_rd=8, id_rt=8, id_uses_rt=1 -> that cycle pc_write=0, ifid_write=0, idex_bubble=1. Next cycle (mem_rd=8, mem_reg_write=1) it advances with fwd_b_sel=10. stall_cnt +1.
- Branch vs load: ex_branch_taken=1 together with load_hz=1 -> ifid_flush=1, idex_bubble=1, pc_write=1, no LOAD_STALL entry, stall_cnt unchanged.
- Memory wait: mem_busy=1 for 3 cycles with fwd_a_sel=10 held -> pipe_freeze=1, pc_write=0 for 3 cycles, fwd_a_sel stays 10, stall_cnt +3. Release cycle follows the normal rules.
- Saturation: CNT_W=4, 20 consecutive mem_busy cycles -> stall_cnt=15 and holds.

Source files
------------

// File: rtl/hazard_ctrl.sv
//==============================================================================
// Module  : hazard_ctrl
// Brief   : Forwarding-select, stall, bubble and flush control for a 5-stage pipe
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_LOAD_STALL = 2'd1,
        S_MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [1:0] c_SEL_RF  = 2'b00;
    localparam logic [1:0] c_SEL_EX  = 2'b01;
    localparam logic [1:0] c_SEL_MEM = 2'b10;

    state_t           r_state;
    logic             w_ex_nz;
    logic             w_mem_nz;
    logic             w_load_hz;
    logic             w_load_stall;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic             w_cnt_sat;

    assign w_ex_nz  = (ex_rd  != '0);
    assign w_mem_nz = (mem_rd != '0);

    assign w_load_hz = ex_mem_read && w_ex_nz &&
                       ((id_uses_rs && (ex_rd == id_rs)) ||
                        (id_uses_rt && (ex_rd == id_rt)));

    // The stalled load has moved to MEM, so a hazard seen in LOAD_STALL is not re-taken.
    assign w_load_stall = w_load_hz && (r_state != S_LOAD_STALL);

    always_comb begin
        w_fwd_a = c_SEL_RF;
        if (id_uses_rs && ex_reg_write && w_ex_nz && (ex_rd == id_rs))
            w_fwd_a = c_SEL_EX;
        else if (id_uses_rs && mem_reg_write && w_mem_nz && (mem_rd == id_rs))
            w_fwd_a = c_SEL_MEM;
    end

    always_comb begin
        w_fwd_b = c_SEL_RF;
        if (id_uses_rt && ex_reg_write && w_ex_nz && (ex_rd == id_rt))
            w_fwd_b = c_SEL_EX;
        else if (id_uses_rt && mem_reg_write && w_mem_nz && (mem_rd == id_rt))
            w_fwd_b = c_SEL_MEM;
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_freeze = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_load_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    assign w_cnt_sat = (stall_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RUN;
            fwd_a_sel <= c_SEL_RF;
            fwd_b_sel <= c_SEL_RF;
            stall_cnt <= '0;
        end else begin
            if (mem_busy) begin
                r_state <= S_MEM_WAIT;
            end else if (ex_branch_taken) begin
                r_state   <= S_RUN;
                fwd_a_sel <= c_SEL_RF;
                fwd_b_sel <= c_SEL_RF;
            end else if (w_load_stall) begin
                r_state   <= S_LOAD_STALL;
                fwd_a_sel <= c_SEL_RF;
                fwd_b_sel <= c_SEL_RF;
            end else begin
                r_state   <= S_RUN;
                fwd_a_sel <= w_fwd_a;
                fwd_b_sel <= w_fwd_b;
            end

            if (!pc_write && !w_cnt_sat)
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//==============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Directed vector bench for hazard_ctrl
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read;
    logic       mem_reg_write, ex_branch_taken, mem_busy;
    logic [1:0] fwd_a_sel, fwd_b_sel, s_fwd_a_sel, s_fwd_b_sel;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;
    logic       s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_pipe_freeze;
    logic [15:0] stall_cnt;
    logic [3:0]  s_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl #(.CNT_W(16), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.CNT_W(4), .REG_W(5)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .idex_bubble(s_idex_bubble), .pipe_freeze(s_pipe_freeze), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] exrd;
        logic       exrw, exmr;
        logic [4:0] memrd;
        logic       memrw, br, busy;
        logic       pc, ifid, flush, bub, frz;  // same-cycle controls
        logic [1:0] fa, fb;                     // after the edge
        logic [15:0] cnt;                       // after the edge
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(string nm,
                                logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                                logic [4:0] exrd, logic exrw, logic exmr,
                                logic [4:0] memrd, logic memrw, logic br, logic busy,
                                logic pc, logic ifid, logic flush, logic bub, logic frz,
                                logic [1:0] fa, logic [1:0] fb, logic [15:0] cnt);
        vec_t v;
        v.name = nm; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.exrd = exrd; v.exrw = exrw; v.exmr = exmr; v.memrd = memrd; v.memrw = memrw;
        v.br = br; v.busy = busy; v.pc = pc; v.ifid = ifid; v.flush = flush;
        v.bub = bub; v.frz = frz; v.fa = fa; v.fb = fb; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_zero();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_rd = 0; mem_reg_write = 0; ex_branch_taken = 0; mem_busy = 0;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
        ex_rd = v.exrd; ex_reg_write = v.exrw; ex_mem_read = v.exmr;
        mem_rd = v.memrd; mem_reg_write = v.memrw;
        ex_branch_taken = v.br; mem_busy = v.busy;
        #2;
        check({v.name, ".ctrl"},
              {27'd0, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze},
              {27'd0, v.pc, v.ifid, v.flush, v.bub, v.frz});
        @(posedge clk);
        #1;
        check({v.name, ".fwd"}, {28'd0, fwd_a_sel, fwd_b_sel}, {28'd0, v.fa, v.fb});
        check({v.name, ".cnt"}, {16'd0, stall_cnt}, {16'd0, v.cnt});
    endtask

    initial begin
        //                 name       rs rt urs urt exrd rw mr memrd mrw br busy  pc if fl bu fz  fa     fb     cnt
        vecs[0]  = mk("ex_fwd",     5, 0, 1, 0,  5, 1, 0,  5, 1, 0, 0,  1, 1, 0, 0, 0, 2'b01, 2'b00, 0);
        vecs[1]  = mk("r0_nofwd",   0, 0, 1, 0,  0, 1, 0,  0, 1, 0, 0,  1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        vecs[2]  = mk("mem_fwd_b",  0, 7, 0, 1,  3, 1, 0,  7, 1, 0, 0,  1, 1, 0, 0, 0, 2'b00, 2'b10, 0);
        vecs[3]  = mk("both_fwd",   4, 9, 1, 1,  4, 1, 0,  9, 1, 0, 0,  1, 1, 0, 0, 0, 2'b01, 2'b10, 0);
        vecs[4]  = mk("unused_rs",  4, 0, 0, 0,  4, 1, 0,  0, 0, 0, 0,  1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        vecs[5]  = mk("load_use",   0, 8, 0, 1,  8, 1, 1,  0, 0, 0, 0,  0, 0, 0, 1, 0, 2'b00, 2'b00, 1);
        vecs[6]  = mk("after_load", 0, 8, 0, 1,  0, 0, 0,  8, 1, 0, 0,  1, 1, 0, 0, 0, 2'b00, 2'b10, 1);
        vecs[7]  = mk("br_vs_load", 2, 0, 1, 0,  2, 1, 1,  0, 0, 1, 0,  1, 1, 1, 1, 0, 2'b00, 2'b00, 1);
        vecs[8]  = mk("set_fa10",   6, 0, 1, 0,  0, 0, 0,  6, 1, 0, 0,  1, 1, 0, 0, 0, 2'b10, 2'b00, 1);
        vecs[9]  = mk("wait1",      6, 0, 1, 0,  6, 1, 0,  0, 0, 0, 1,  0, 0, 0, 0, 1, 2'b10, 2'b00, 2);
        vecs[10] = mk("wait2_br",   6, 0, 1, 0,  6, 1, 0,  0, 0, 1, 1,  0, 0, 0, 0, 1, 2'b10, 2'b00, 3);
        vecs[11] = mk("wait3",      6, 0, 1, 0,  6, 1, 0,  0, 0, 0, 1,  0, 0, 0, 0, 1, 2'b10, 2'b00, 4);
        vecs[12] = mk("release",    6, 0, 1, 0,  6, 1, 0,  0, 0, 0, 0,  1, 1, 0, 0, 0, 2'b01, 2'b00, 4);
        vecs[13] = mk("wait_hz",    0, 8, 0, 1,  8, 1, 1,  0, 0, 0, 1,  0, 0, 0, 0, 1, 2'b01, 2'b00, 5);
        vecs[14] = mk("rel_load",   0, 8, 0, 1,  8, 1, 1,  0, 0, 0, 0,  0, 0, 0, 1, 0, 2'b00, 2'b00, 6);
        vecs[15] = mk("idle",       0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 1, 0, 0, 0, 2'b00, 2'b00, 6);

        drive_zero();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.fwd", {28'd0, fwd_a_sel, fwd_b_sel}, 32'd0);
        check("reset.cnt", {16'd0, stall_cnt}, 32'd0);
        check("reset.pc_write", {31'd0, pc_write}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) apply(vecs[i]);

        // Asynchronous reset landing mid-cycle while in MEM_WAIT with fwd_a_sel held at 01.
        apply(mk("pre_rst_fwd", 3, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b01, 2'b00, 6));
        apply(mk("pre_rst_wait", 3, 0, 1, 0, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b01, 2'b00, 7));
        #2;
        rst_n = 1'b0;
        drive_zero();
        #1;
        check("async_rst.fwd", {28'd0, fwd_a_sel, fwd_b_sel}, 32'd0);
        check("async_rst.cnt", {16'd0, stall_cnt}, 32'd0);
        check("async_rst.ctrl",
              {27'd0, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}, 32'b11000);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("post_rst.pc_write", {31'd0, pc_write}, 32'd1);

        // 20 consecutive memory-wait cycles: narrow counter saturates, wide one counts on.
        @(negedge clk);
        mem_busy = 1'b1;
        for (int i = 0; i < 20; i++) @(posedge clk);
        #1;
        check("sat.cnt4", {28'd0, s_stall_cnt}, 32'd15);
        check("sat.cnt16", {16'd0, stall_cnt}, 32'd20);
        @(posedge clk);
        #1;
        check("sat.hold", {28'd0, s_stall_cnt}, 32'd15);
        @(negedge clk);
        mem_busy = 1'b0;
        @(posedge clk);
        #1;
        check("sat.release", {28'd0, s_stall_cnt}, 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
